// File: rtl/imuldiv_mul_resp_queue_pkg.sv
// Shared constants and types for the multiplier response queue.
// Tag field layout, product/result widths, output stage states.
package imuldiv_mul_resp_queue_pkg;

  localparam int TAG_HI_BIT = 0;
  localparam int RESULT_W   = 64;
  localparam int OUT_W      = 32;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/imuldiv_mul_resp_queue_tag_fifo.sv
// In-order tag FIFO tracking outstanding multiplies.
// Push is refused when full even if a pop happens the same cycle.
module imuldiv_tag_fifo #(
  parameter int DEPTH = 2,
  parameter int TAG_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [TAG_W-1:0] i_tag,
  input  logic             i_pop,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [TAG_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_tag   = r_mem[r_rd_ptr];

  // storage deliberately left out of reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/imuldiv_mul_resp_queue.sv
// Request/response adapter for the iterative multiplier.
// Tags requests in order and returns the selected 32-bit half.
module imuldiv_mul_resp_queue
  import imuldiv_mul_resp_queue_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int TAG_W = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_val,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                in_rdy,
  output logic                mul_req_val,
  input  logic                mul_req_rdy,
  input  logic [RESULT_W-1:0] mul_resp_result,
  input  logic                mul_resp_val,
  output logic                mul_resp_rdy,
  output logic [OUT_W-1:0]    out_result,
  output logic [TAG_W-1:0]    out_tag,
  output logic                out_val,
  input  logic                out_rdy
);

  out_state_t r_state;
  out_state_t w_state_nxt;

  logic [OUT_W-1:0] r_result;
  logic [TAG_W-1:0] r_tag;

  logic             w_full;
  logic             w_empty;
  logic [TAG_W-1:0] w_tag_rd;
  logic             w_req_fire;
  logic             w_resp_fire;
  logic [OUT_W-1:0] w_half;

  assign mul_req_val  = in_val & ~w_full;
  assign in_rdy       = reset & mul_req_rdy & ~w_full;
  assign w_req_fire   = in_val & in_rdy;
  assign mul_resp_rdy = reset & ~w_empty & (~out_val | out_rdy);
  assign w_resp_fire  = mul_resp_val & mul_resp_rdy;

  assign w_half = w_tag_rd[TAG_HI_BIT]
                ? mul_resp_result[RESULT_W-1:OUT_W]
                : mul_resp_result[OUT_W-1:0];

  imuldiv_tag_fifo #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_tag_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_req_fire),
    .i_tag   (in_tag),
    .i_pop   (w_resp_fire),
    .o_tag   (w_tag_rd),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= OUT_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      OUT_EMPTY: begin
        if (w_resp_fire) w_state_nxt = OUT_FULL;
      end
      OUT_FULL: begin
        if (out_rdy & ~w_resp_fire) w_state_nxt = OUT_EMPTY;
      end
      default: w_state_nxt = OUT_EMPTY;
    endcase
  end

  always_comb begin
    out_val = (r_state == OUT_FULL);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_result <= '0;
      r_tag    <= '0;
    end else if (w_resp_fire) begin
      r_result <= w_half;
      r_tag    <= w_tag_rd;
    end
  end

  assign out_result = r_result;
  assign out_tag    = r_tag;

endmodule

// File: doc/imuldiv_mul_resp_queue.md
Name: imuldiv_mul_resp_queue

Overview:
Adapter that sits between the issuing stage and the iterative multiplier. It forwards operand requests to the multiplier and records a per-request tag in an in-order tag FIFO. It then consumes the multiplier's 64-bit response and returns a registered 32-bit result, either the high or low half as selected by the tag. It bounds the number of outstanding multiplies and provides a registered output stage for the writeback side.

Parameters:
DEPTH, 2, tag FIFO entries and maximum outstanding multiplies; power of 2, at least 2
TAG_W, 2, tag width; bit 0 = half select (1 = result[63:32], 0 = result[31:0]); all bits returned unchanged

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  synchronous, active-low (0 = reset, sampled on posedge clk)
in_val  input  1  requester has a multiply to issue
in_tag  input  TAG_W  tag for that request
in_rdy  output  1  request accepted this cycle when in_val is also 1
mul_req_val  output  1  valid to the multiplier request interface
mul_req_rdy  input  1  multiplier request ready
mul_resp_result  input  64  multiplier product
mul_resp_val  input  1  multiplier response valid
mul_resp_rdy  output  1  adapter consumes the response
out_result  output  32  selected half of the product
out_tag  output  TAG_W  tag of this result
out_val  output  1  result valid
out_rdy  input  1  consumer ready

Behaviour:
- Operands go straight from requester to multiplier; this block only gates the handshake.
- tag_full = (count == DEPTH); tag_empty = (count == 0). Both derive from the registered count only.
- Gating:
  - mul_req_val = in_val & !tag_full
  - in_rdy = mul_req_rdy & !tag_full
  - req_fire = in_val & in_rdy
- On req_fire: write in_tag at wr_ptr; wr_ptr wraps modulo DEPTH.
- Full boundary: no same-cycle bypass. When full, push is blocked even if a pop occurs in the same cycle.
- Out-register states: EMPTY (out_val = 0) and FULL (out_val = 1).
- mul_resp_rdy = !tag_empty & (!out_val | out_rdy).
- resp_fire = mul_resp_val & mul_resp_rdy. On resp_fire:
  - pop the tag at rd_ptr; rd_ptr wraps modulo DEPTH
  - out_result <= tag[0] ? mul_resp_result[63:32] : mul_resp_result[31:0]
  - out_tag <= popped tag; out_val <= 1
- Latency: the result is visible on out_* the cycle after resp_fire.
- Out register transitions:
  - FULL -> EMPTY on out_rdy & !resp_fire
  - FULL -> FULL with new data on out_rdy & resp_fire, giving one result per cycle
  - EMPTY -> FULL on resp_fire
- While out_val = 1 and out_rdy = 0, out_result and out_tag hold stable.
- Count update: +1 on push only, -1 on pop only, unchanged when both or neither occur.
- Empty boundary: mul_resp_val with the tag FIFO empty is a protocol violation. It is ignored: mul_resp_rdy stays 0 and no state changes.
- Responses are assumed to return in issue order; the tag FIFO is strictly FIFO.
- Reset:
  - count = 0, wr_ptr = 0, rd_ptr = 0, out_val = 0
  - out_result = 0, out_tag = 0
  - in_rdy and mul_resp_rdy are 0 while reset is asserted
- Reset mid-operation discards all outstanding tags and any held result. A stale multiplier response arriving after reset sees an empty FIFO and is ignored.
- FIFO storage array is not reset.

Decomposition:
- Shared package holds:
  - tag field constants: TAG_HI_BIT = 0
  - half widths: RESULT_W = 64, OUT_W = 32
- One sub-module: imuldiv_tag_fifo (parameters DEPTH and TAG_W; push/pop, full/empty, count).
- The half-select mux and output register stay in the top module.

Test Plan:
- Low half: issue in_tag = 2'b00; multiplier returns 64'h0000_0001_FFFF_FFFE -> one cycle later out_result = 32'hFFFF_FFFE, out_tag = 2'b00, out_val = 1.
- High half: issue in_tag = 2'b11; multiplier returns 64'hFFFF_FFFF_8000_0000 -> out_result = 32'hFFFF_FFFF, out_tag = 2'b11.
- Full back-pressure: with DEPTH = 2, issue two requests and withhold responses -> after the second accept, in_rdy = 0 and mul_req_val = 0 despite in_val = 1 and mul_req_rdy = 1.
- Simultaneous pop/push at full: return one response while in_val = 1 -> no accept that cycle; accept on the next cycle; count returns to 2.
- Output stall: hold out_rdy = 0 with a result held and a second response valid -> mul_resp_rdy = 0 and out_* stable. Then raise out_rdy -> second result loads next cycle.
- Reset: assert reset = 0 with two requests outstanding -> out_val = 0, in_rdy = 0. After release, a stray mul_resp_val = 1 gives mul_resp_rdy = 0 and out_val stays 0.
